// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with skid buffer; FETCH_ALIGN_CHK_EN enables misaligned-redirect flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stay,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_unit_if.master  imem,
  output logic [31:0]   PCp4_o,
  output logic [31:0]   ins_o,
  output logic          ins_valid,
  output logic          fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_p4;
  logic [31:0] drop_addr;
  logic [31:0] redirect_tgt;
  logic        sk_valid;
  logic [31:0] sk_ins;
  logic [31:0] sk_pcp4;
  logic        acked;
  logic        accept;

  // A word is only kept when it completes in FETCH and no redirect overrides it.
  assign acked        = imem.imem_req && imem.imem_ack;
  assign accept       = (state == FETCH) && acked && !redirect;
  assign pc_p4        = pc + 32'd4;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: redirect beats ack and stay; an unacked outstanding request must be drained in DROP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          state_nxt = acked ? FETCH : DROP;
        end else if (accept && stay && ins_valid) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = FETCH;
        end
      end
      HOLD: begin
        if (redirect || !stay) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (acked) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus outputs: request in FETCH/DROP; DROP keeps presenting the abandoned address.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    case (state)
      FETCH: begin
        imem.imem_req = 1'b1;
      end
      DROP: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = drop_addr;
      end
      default: begin
        imem.imem_req = 1'b0;
      end
    endcase
  end

  // Program counter and the address held while draining a dropped request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        pc <= redirect_tgt;
      end else if (accept) begin
        pc <= pc_p4;
      end
      if ((state == FETCH) && (state_nxt == DROP)) begin
        drop_addr <= pc;
      end
    end
  end

  // Output register and one-entry skid: flush on redirect, park a word that lands during a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_valid <= 1'b0;
      ins_o     <= 32'd0;
      PCp4_o    <= 32'd0;
      sk_valid  <= 1'b0;
      sk_ins    <= 32'd0;
      sk_pcp4   <= 32'd0;
    end else if (redirect) begin
      ins_valid <= 1'b0;
      ins_o     <= 32'd0;
      PCp4_o    <= 32'd0;
      sk_valid  <= 1'b0;
      sk_ins    <= 32'd0;
      sk_pcp4   <= 32'd0;
    end else if (accept) begin
      if (!stay || !ins_valid) begin
        ins_valid <= 1'b1;
        ins_o     <= imem.imem_rdata;
        PCp4_o    <= pc_p4;
      end else begin
        sk_valid <= 1'b1;
        sk_ins   <= imem.imem_rdata;
        sk_pcp4  <= pc_p4;
      end
    end else if (!stay) begin
      if (sk_valid) begin
        ins_valid <= 1'b1;
        ins_o     <= sk_ins;
        PCp4_o    <= sk_pcp4;
        sk_valid  <= 1'b0;
      end else begin
        ins_valid <= 1'b0;
        ins_o     <= 32'd0;
        PCp4_o    <= 32'd0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  // One-cycle flag for a redirect target with nonzero low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the `PCp4`/`ins` pair consumed by the IF/ID pipeline register. It owns the program counter and issues requests to a variable-latency instruction memory over a req/ack handshake. It holds its output while the downstream hazard unit asserts `stay`, and flushes to a bubble on a branch or jump redirect. A one-entry skid buffer absorbs a fetch that completes while the pipeline is stalled.

## Interface

Parameters:

- `RESET_PC`, default 32'h0040_0000: PC fetched first after reset.

Ports:

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `stay`  in  1  downstream stall; the output must be held this edge
- `redirect`  in  1  branch/jump taken this cycle; single-cycle pulse
- `redirect_pc`  in  32  target PC, valid while `redirect`=1
- `imem_req`  out  1  fetch request; held until ack
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1
- `imem_ack`  in  1  request completes on a cycle with `imem_req`&&`imem_ack`
- `imem_rdata`  in  32  instruction word, valid on the ack cycle
- `PCp4_o`  out  32  fetched address + 4; goes to IF/ID `PCp4_i`
- `ins_o`  out  32  instruction; goes to IF/ID `ins_i`; 0 (NOP) when not valid
- `ins_valid`  out  1  `ins_o`/`PCp4_o` hold a real instruction
- `fetch_err`  out  1  misaligned redirect flag (see Configuration)

## Operation

- State machine states: IDLE, FETCH, HOLD, DROP. Reset state is IDLE.
- Registers: `pc`; output register {`ins_valid`, `ins_o`, `PCp4_o`}; skid register {`sk_valid`, `sk_ins`, `sk_pcp4`}.
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`, `ins_o`=0, `PCp4_o`=0, `ins_valid`=0, skid empty, `fetch_err`=0.
- IDLE: on the first edge after reset is released, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. On ack, with no redirect, the word is accepted and `pc` advances by 4. Address arithmetic is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- Accepted word with `stay`=0: it loads the output register with `ins_valid`=1 and `PCp4_o`=addr+4. The state stays in FETCH.
- Accepted word with `stay`=1 and `ins_valid`=0: it loads the output register directly.
- Accepted word with `stay`=1 and `ins_valid`=1: it loads the skid register and the state goes to HOLD. No request is issued while in HOLD.
- Edge with `stay`=0 and no accepted word: the output register loads from the skid if the skid is full, otherwise it becomes a bubble (valid=0, `ins_o`=0, `PCp4_o`=0).
- HOLD: on the first edge with `stay`=0, the skid moves to the output register, the skid empties, and the state returns to FETCH.
- Redirect has priority over `stay` and over ack. On a redirect edge:
  - the output register becomes a bubble and the skid is cleared;
  - `pc` loads `{redirect_pc[31:2],2'b00}`;
  - any word acked that same cycle is discarded.
- Redirect while a request is outstanding and not acked this cycle: go to DROP.
- Redirect in any other case (including an ack in the same cycle): go to FETCH, so the new PC is requested the next cycle.
- DROP: `imem_req`=1 with the old address, held stable. The word returned on ack is discarded and the state goes to FETCH with the redirected `pc`. A further redirect while in DROP only updates `pc`.
- Reset asserted mid-operation clears everything asynchronously, and `imem_req` drops immediately. The instruction memory must tolerate an abandoned request.

## Timing

- `imem_ack` may assert in the same cycle `imem_req` rises, giving zero-wait memory.
- An acked word appears on the outputs one cycle after the ack edge.
- Throughput is 1 instruction/cycle when ack is combinational and `stay`=0.
- First `imem_req` rises 1 cycle after reset release.
- After a redirect edge, `imem_addr` shows the target 1 cycle later (no outstanding request), or 1 cycle after the dropped ack (request outstanding).
- Outputs only change on `clk`, apart from the asynchronous reset.

## Configuration

- Macro `FETCH_ALIGN_CHK_EN`.
- Defined: a redirect with `redirect_pc[1:0]`≠0 sets `fetch_err`=1 for exactly the following cycle. Fetch still proceeds with the low 2 bits forced to 00.
- Undefined: `fetch_err` is tied to 0 and the low bits are silently forced to 00.

## Test plan

- Reset release, zero-wait memory, `stay`=0 -> `imem_addr` runs 0x00400000, 0x00400004, …; `ins_valid`=1 from cycle 2 onward; `PCp4_o` = address+4.
- `stay` held high 3 cycles while acks continue -> output held, one word parked in skid, `imem_req`=0 while in HOLD; after `stay` falls, words arrive in order with none lost or duplicated.
- 2-cycle memory latency, redirect to 0x00400100 one cycle after req -> old word discarded in DROP, next `imem_addr`=0x00400100, output is a bubble in between.
- Redirect and ack in the same cycle, with `stay`=1 -> redirect wins: output bubble, skid empty, next fetch at target.
- `pc`=0xFFFFFFFC -> next `imem_addr`=0x00000000 and `PCp4_o`=0x00000000.
- With `FETCH_ALIGN_CHK_EN`, redirect to 0x00400102 -> `fetch_err` pulses 1 cycle and fetch proceeds at 0x00400100. Assert reset mid-fetch -> `imem_req`=0 and all outputs 0 immediately.
